// File: rtl/cpu_pkg.sv
// Shared constants for the datapath and its control FSM: widths, bus read codes
// and write/inc/clr strobe bit positions.
package cpu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned RD_W     = 4;
  localparam int unsigned CMD_W    = 16;

  // Bus source select codes
  localparam logic [RD_W-1:0] RD_NONE = 4'd0;
  localparam logic [RD_W-1:0] RD_PC   = 4'd1;
  localparam logic [RD_W-1:0] RD_AR   = 4'd2;
  localparam logic [RD_W-1:0] RD_DR   = 4'd3;
  localparam logic [RD_W-1:0] RD_IR   = 4'd4;
  localparam logic [RD_W-1:0] RD_AC   = 4'd5;
  localparam logic [RD_W-1:0] RD_R    = 4'd6;
  localparam logic [RD_W-1:0] RD_R1   = 4'd7;
  localparam logic [RD_W-1:0] RD_R2   = 4'd8;
  localparam logic [RD_W-1:0] RD_R3   = 4'd9;
  localparam logic [RD_W-1:0] RD_R4   = 4'd10;
  localparam logic [RD_W-1:0] RD_R5   = 4'd11;
  localparam logic [RD_W-1:0] RD_DM   = 4'd12;
  localparam logic [RD_W-1:0] RD_IM   = 4'd13;
  localparam logic [RD_W-1:0] RD_AC_R = 4'd14;

  // Strobe bit positions shared by write_en, inc_en and clr_en
  localparam int unsigned WB_PC     = 1;
  localparam int unsigned WB_AR     = 2;
  localparam int unsigned WB_IR     = 3;
  localparam int unsigned WB_AC     = 4;
  localparam int unsigned WB_R      = 5;
  localparam int unsigned WB_R4     = 6;
  localparam int unsigned WB_R3     = 7;
  localparam int unsigned WB_R2     = 8;
  localparam int unsigned WB_R1     = 9;
  localparam int unsigned WB_DM     = 11;
  localparam int unsigned WB_ALU_AC = 12;
  localparam int unsigned WB_AC_R   = 13;
  localparam int unsigned WB_R5     = 14;

endpackage

// File: rtl/datapath_bus_if.sv
// Control/memory interface of the datapath: FSM commands, ALU and memory
// connections, and the status returned to control.
interface datapath_bus_if #(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned OPCODE_W = cpu_pkg::OPCODE_W
);
  logic [cpu_pkg::RD_W-1:0]  read_en;
  logic [cpu_pkg::CMD_W-1:0] write_en;
  logic [cpu_pkg::CMD_W-1:0] inc_en;
  logic [cpu_pkg::CMD_W-1:0] clr_en;
  logic                      halt;
  logic [DATA_W-1:0]         alu_result;
  logic [DATA_W-1:0]         ac_out;
  logic [DATA_W-1:0]         r_out;
  logic [OPCODE_W-1:0]       instruction;
  logic                      z;
  logic [ADDR_W-1:0]         im_addr;
  logic [DATA_W-1:0]         im_rdata;
  logic [ADDR_W-1:0]         dm_addr;
  logic [DATA_W-1:0]         dm_rdata;
  logic [DATA_W-1:0]         dm_wdata;
  logic                      dm_we;

  modport master (
    output read_en, write_en, inc_en, clr_en, halt, alu_result, im_rdata, dm_rdata,
    input  ac_out, r_out, instruction, z, im_addr, dm_addr, dm_wdata, dm_we
  );

  modport slave (
    input  read_en, write_en, inc_en, clr_en, halt, alu_result, im_rdata, dm_rdata,
    output ac_out, r_out, instruction, z, im_addr, dm_addr, dm_wdata, dm_we
  );
endinterface

// File: rtl/dp_reg.sv
// Register with clear/load/increment, priority clr > load > inc; en gates all updates.
module dp_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (clr)       q <= '0;
      else if (load) q <= d;
      else if (inc)  q <= q + W'(1);
    end
  end

endmodule

// File: rtl/datapath_bus.sv
// Datapath: architectural registers plus a registered shared bus driven by the control FSM.
// Optional register R5 is built when DATAPATH_R5_EN is defined.
module datapath_bus #(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned OPCODE_W = cpu_pkg::OPCODE_W
) (
  input  logic           clk,
  input  logic           rst,
  datapath_bus_if.slave  bus
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] bus_q, bus_d;
  logic [ADDR_W-1:0] pc_q, ar_q;
  logic [DATA_W-1:0] ac_q, r_q, dr_q, ir_q;
  logic [DATA_W-1:0] r1_q, r2_q, r3_q, r4_q;
  logic [DATA_W-1:0] ac_d, r_d;
  logic              upd;
`ifdef DATAPATH_R5_EN
  logic [DATA_W-1:0] r5_q;
`endif

  assign upd = ~bus.halt;

  dp_reg #(.W(ADDR_W)) u_pc (
    .clk(clk), .rst(rst), .en(upd),
    .clr(bus.clr_en[WB_PC]), .load(bus.write_en[WB_PC]), .inc(bus.inc_en[WB_PC]),
    .d(bus_q[ADDR_W-1:0]), .q(pc_q)
  );

  dp_reg #(.W(ADDR_W)) u_ar (
    .clk(clk), .rst(rst), .en(upd),
    .clr(bus.clr_en[WB_AR]), .load(bus.write_en[WB_AR]), .inc(bus.inc_en[WB_AR]),
    .d(bus_q[ADDR_W-1:0]), .q(ar_q)
  );

  // Direct ALU and AC->R paths take precedence over the bus load
  assign ac_d = bus.write_en[WB_ALU_AC] ? bus.alu_result : bus_q;
  assign r_d  = bus.write_en[WB_AC_R]   ? ac_q           : bus_q;

  dp_reg #(.W(DATA_W)) u_ac (
    .clk(clk), .rst(rst), .en(upd),
    .clr(bus.clr_en[WB_AC]), .load(bus.write_en[WB_AC] | bus.write_en[WB_ALU_AC]),
    .inc(bus.inc_en[WB_AC]), .d(ac_d), .q(ac_q)
  );

  dp_reg #(.W(DATA_W)) u_r (
    .clk(clk), .rst(rst), .en(upd),
    .clr(bus.clr_en[WB_R]), .load(bus.write_en[WB_R] | bus.write_en[WB_AC_R]),
    .inc(bus.inc_en[WB_R]), .d(r_d), .q(r_q)
  );

  // Bus source select
  always_comb begin
    bus_d = '0;
    case (bus.read_en)
      RD_PC:   bus_d = DATA_W'(pc_q);
      RD_AR:   bus_d = DATA_W'(ar_q);
      RD_DR:   bus_d = dr_q;
      RD_IR:   bus_d = ir_q;
      RD_AC:   bus_d = ac_q;
      RD_R:    bus_d = r_q;
      RD_R1:   bus_d = r1_q;
      RD_R2:   bus_d = r2_q;
      RD_R3:   bus_d = r3_q;
      RD_R4:   bus_d = r4_q;
`ifdef DATAPATH_R5_EN
      RD_R5:   bus_d = r5_q;
`endif
      RD_DM:   bus_d = bus.dm_rdata;
      RD_IM:   bus_d = bus.im_rdata;
      RD_AC_R: bus_d = ac_q;
      default: bus_d = '0;
    endcase
  end

  // bus_q captures every cycle, even while halted
  always_ff @(posedge clk) begin
    if (rst) bus_q <= '0;
    else     bus_q <= bus_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_q <= '0;
      ir_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      r4_q <= '0;
    end else if (upd) begin
      if (bus.read_en == RD_DM)  dr_q <= bus.dm_rdata;
      if (bus.write_en[WB_IR])   ir_q <= bus_q;
      if (bus.write_en[WB_R1])   r1_q <= bus_q;
      if (bus.write_en[WB_R2])   r2_q <= bus_q;
      if (bus.write_en[WB_R3])   r3_q <= bus_q;
      if (bus.write_en[WB_R4])   r4_q <= bus_q;
    end
  end

`ifdef DATAPATH_R5_EN
  always_ff @(posedge clk) begin
    if (rst)                              r5_q <= '0;
    else if (upd && bus.write_en[WB_R5])  r5_q <= bus_q;
  end
`endif

  assign bus.ac_out      = ac_q;
  assign bus.r_out       = r_q;
  assign bus.instruction = ir_q[OPCODE_W-1:0];
  assign bus.z           = (ac_q == '0);
  assign bus.im_addr     = pc_q;
  assign bus.dm_addr     = ar_q;
  assign bus.dm_wdata    = bus_q;
  assign bus.dm_we       = bus.write_en[WB_DM] & ~bus.halt & ~rst;

  // Strobe bits with no destination in this configuration
  logic unused_strobes;
`ifdef DATAPATH_R5_EN
  assign unused_strobes = ^{bus.write_en[0], bus.write_en[10], bus.write_en[15],
                            bus.inc_en[0], bus.inc_en[3], bus.inc_en[15:6],
                            bus.clr_en[0], bus.clr_en[3], bus.clr_en[15:6]};
`else
  assign unused_strobes = ^{bus.write_en[0], bus.write_en[10], bus.write_en[15:14],
                            bus.inc_en[0], bus.inc_en[3], bus.inc_en[15:6],
                            bus.clr_en[0], bus.clr_en[3], bus.clr_en[15:6]};
`endif

endmodule

// File: tb/tb_datapath_bus.sv
// Self-checking bench for datapath_bus: directed scenarios plus randomized traffic
// compared against a behavioural register-file model. Honours DATAPATH_R5_EN.
module tb_datapath_bus;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  datapath_bus_if dif ();

  datapath_bus dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_pc, m_ar, m_dr, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4, m_bus;
`ifdef DATAPATH_R5_EN
  logic [15:0] m_r5;
`endif

  task automatic drive(input logic [3:0] rd, input logic [15:0] we,
                       input logic [15:0] inc, input logic [15:0] clr);
    dif.read_en  = rd;
    dif.write_en = we;
    dif.inc_en   = inc;
    dif.clr_en   = clr;
  endtask

  // Advance one clock and apply the same cycle to the model
  task automatic tick();
    logic [15:0] src [16];
    logic [15:0] we, inc, clr, ac_old;
    @(posedge clk);
    we  = dif.write_en;
    inc = dif.inc_en;
    clr = dif.clr_en;
    if (rst) begin
      {m_pc, m_ar, m_dr, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4, m_bus} = '0;
`ifdef DATAPATH_R5_EN
      m_r5 = 16'h0;
`endif
    end else begin
      foreach (src[i]) src[i] = 16'h0;
      src[1] = m_pc;  src[2] = m_ar;  src[3] = m_dr;  src[4] = m_ir;
      src[5] = m_ac;  src[6] = m_r;   src[7] = m_r1;  src[8] = m_r2;
      src[9] = m_r3;  src[10] = m_r4; src[12] = dif.dm_rdata;
      src[13] = dif.im_rdata; src[14] = m_ac;
`ifdef DATAPATH_R5_EN
      src[11] = m_r5;
`endif
      if (!dif.halt) begin
        ac_old = m_ac;
        if (dif.read_en == 4'd12) m_dr = dif.dm_rdata;
        if (we[3]) m_ir = m_bus;
        if (we[9]) m_r1 = m_bus;
        if (we[8]) m_r2 = m_bus;
        if (we[7]) m_r3 = m_bus;
        if (we[6]) m_r4 = m_bus;
`ifdef DATAPATH_R5_EN
        if (we[14]) m_r5 = m_bus;
`endif
        m_pc = clr[1] ? 16'h0 : we[1] ? m_bus : inc[1] ? m_pc + 16'd1 : m_pc;
        m_ar = clr[2] ? 16'h0 : we[2] ? m_bus : inc[2] ? m_ar + 16'd1 : m_ar;
        m_ac = clr[4] ? 16'h0 : we[12] ? dif.alu_result : we[4] ? m_bus
             : inc[4] ? m_ac + 16'd1 : m_ac;
        m_r  = clr[5] ? 16'h0 : we[13] ? ac_old : we[5] ? m_bus
             : inc[5] ? m_r + 16'd1 : m_r;
      end
      m_bus = src[dif.read_en];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.halt = 1'b0; dif.alu_result = 16'hFFFF; dif.im_rdata = 16'hFFFF; dif.dm_rdata = 16'hFFFF;
    drive(4'hD, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tick(); tick();
    n_checks++; if (dif.ac_out !== 16'h0)   begin n_errors++; $display("FAIL reset_ac got=%h exp=0000", dif.ac_out); end
    n_checks++; if (dif.r_out !== 16'h0)    begin n_errors++; $display("FAIL reset_r got=%h exp=0000", dif.r_out); end
    n_checks++; if (dif.im_addr !== 16'h0)  begin n_errors++; $display("FAIL reset_pc got=%h exp=0000", dif.im_addr); end
    n_checks++; if (dif.dm_addr !== 16'h0)  begin n_errors++; $display("FAIL reset_ar got=%h exp=0000", dif.dm_addr); end
    n_checks++; if (dif.dm_wdata !== 16'h0) begin n_errors++; $display("FAIL reset_bus got=%h exp=0000", dif.dm_wdata); end
    n_checks++; if (dif.instruction !== 6'h0) begin n_errors++; $display("FAIL reset_ir got=%h exp=00", dif.instruction); end
    n_checks++; if (dif.z !== 1'b1)         begin n_errors++; $display("FAIL reset_z got=%b exp=1", dif.z); end
    n_checks++; if (dif.dm_we !== 1'b0)     begin n_errors++; $display("FAIL reset_dm_we got=%b exp=0", dif.dm_we); end
    rst = 1'b0;
    drive(4'd0, 16'h0, 16'h0, 16'h0);
    tick();
  endtask

  task automatic test_fetch();
    dif.im_rdata = 16'h0013;
    drive(4'd13, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h0008, 16'h0, 16'h0); tick();
    n_checks++; if (dif.instruction !== 6'd19) begin n_errors++; $display("FAIL fetch_ir got=%0d exp=19", dif.instruction); end
    drive(4'd0, 16'h0, 16'h0002, 16'h0); tick();
    n_checks++; if (dif.im_addr !== 16'h0001) begin n_errors++; $display("FAIL fetch_pc_inc got=%h exp=0001", dif.im_addr); end
  endtask

  task automatic test_store_load();
    dif.im_rdata = 16'h0040; drive(4'd13, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h0004, 16'h0, 16'h0); tick();
    dif.im_rdata = 16'h00A5; drive(4'd13, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h0010, 16'h0, 16'h0); tick();
    drive(4'd5, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h0800, 16'h0, 16'h0); #1;
    n_checks++; if (dif.dm_we !== 1'b1)         begin n_errors++; $display("FAIL store_we got=%b exp=1", dif.dm_we); end
    n_checks++; if (dif.dm_wdata !== 16'h00A5)  begin n_errors++; $display("FAIL store_wdata got=%h exp=00a5", dif.dm_wdata); end
    n_checks++; if (dif.dm_addr !== 16'h0040)   begin n_errors++; $display("FAIL store_addr got=%h exp=0040", dif.dm_addr); end
    tick();
    drive(4'd0, 16'h0, 16'h0, 16'h0); #1;
    n_checks++; if (dif.dm_we !== 1'b0)         begin n_errors++; $display("FAIL store_we_pulse got=%b exp=0", dif.dm_we); end
    dif.dm_rdata = 16'h1234; drive(4'd12, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h0010, 16'h0, 16'h0); tick();
    n_checks++; if (dif.ac_out !== 16'h1234)    begin n_errors++; $display("FAIL load_ac got=%h exp=1234", dif.ac_out); end
    dif.dm_rdata = 16'h0BAD; drive(4'd3, 16'h0, 16'h0, 16'h0); tick();
    n_checks++; if (dif.dm_wdata !== 16'h1234)  begin n_errors++; $display("FAIL load_dr got=%h exp=1234", dif.dm_wdata); end
  endtask

  task automatic test_priority();
    dif.im_rdata = 16'h0005; drive(4'd13, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h0002, 16'h0, 16'h0); tick();
    n_checks++; if (dif.im_addr !== 16'h0005) begin n_errors++; $display("FAIL prio_pc_setup got=%h exp=0005", dif.im_addr); end
    dif.im_rdata = 16'h0020; drive(4'd13, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h0002, 16'h0002, 16'h0); tick();
    n_checks++; if (dif.im_addr !== 16'h0020) begin n_errors++; $display("FAIL prio_write_over_inc got=%h exp=0020", dif.im_addr); end
    drive(4'd0, 16'h0002, 16'h0002, 16'h0002); tick();
    n_checks++; if (dif.im_addr !== 16'h0000) begin n_errors++; $display("FAIL prio_clr got=%h exp=0000", dif.im_addr); end
  endtask

  task automatic test_alu_wrap();
    dif.im_rdata = 16'hFFFF; drive(4'd13, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h0010, 16'h0, 16'h0); tick();
    n_checks++; if (dif.z !== 1'b0)          begin n_errors++; $display("FAIL wrap_z_pre got=%b exp=0", dif.z); end
    drive(4'd0, 16'h0, 16'h0010, 16'h0); tick();
    n_checks++; if (dif.ac_out !== 16'h0000) begin n_errors++; $display("FAIL wrap_ac got=%h exp=0000", dif.ac_out); end
    n_checks++; if (dif.z !== 1'b1)          begin n_errors++; $display("FAIL wrap_z got=%b exp=1", dif.z); end
    dif.alu_result = 16'h0007; dif.im_rdata = 16'h0099;
    drive(4'd13, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h1010, 16'h0, 16'h0); tick();
    n_checks++; if (dif.ac_out !== 16'h0007) begin n_errors++; $display("FAIL alu_over_bus got=%h exp=0007", dif.ac_out); end
    n_checks++; if (dif.z !== 1'b0)          begin n_errors++; $display("FAIL alu_z got=%b exp=0", dif.z); end
    drive(4'd0, 16'h2020, 16'h0, 16'h0); tick();
    n_checks++; if (dif.r_out !== 16'h0007)  begin n_errors++; $display("FAIL ac_to_r got=%h exp=0007", dif.r_out); end
  endtask

  task automatic test_halt();
    dif.halt = 1'b1; dif.im_rdata = 16'hBEEF;
    drive(4'd13, 16'h0FFE, 16'h0036, 16'h0); #1;
    n_checks++; if (dif.dm_we !== 1'b0) begin n_errors++; $display("FAIL halt_dm_we got=%b exp=0", dif.dm_we); end
    tick(); tick();
    n_checks++; if (dif.ac_out !== 16'h0007)  begin n_errors++; $display("FAIL halt_ac got=%h exp=0007", dif.ac_out); end
    n_checks++; if (dif.r_out !== 16'h0007)   begin n_errors++; $display("FAIL halt_r got=%h exp=0007", dif.r_out); end
    n_checks++; if (dif.im_addr !== 16'h0000) begin n_errors++; $display("FAIL halt_pc got=%h exp=0000", dif.im_addr); end
    n_checks++; if (dif.dm_addr !== 16'h0040) begin n_errors++; $display("FAIL halt_ar got=%h exp=0040", dif.dm_addr); end
    n_checks++; if (dif.instruction !== 6'd19) begin n_errors++; $display("FAIL halt_ir got=%0d exp=19", dif.instruction); end
    n_checks++; if (dif.dm_wdata !== 16'hBEEF) begin n_errors++; $display("FAIL halt_bus_capture got=%h exp=beef", dif.dm_wdata); end
    dif.halt = 1'b0;
    drive(4'd0, 16'h0, 16'h0, 16'h0); tick();
  endtask

  task automatic test_r5();
    logic [15:0] exp;
`ifdef DATAPATH_R5_EN
    exp = 16'h55AA;
`else
    exp = 16'h0000;
`endif
    dif.im_rdata = 16'h55AA; drive(4'd13, 16'h0, 16'h0, 16'h0); tick();
    drive(4'd0, 16'h4000, 16'h0, 16'h0); tick();
    drive(4'd11, 16'h0, 16'h0, 16'h0); tick();
    n_checks++; if (dif.dm_wdata !== exp) begin n_errors++; $display("FAIL r5_read got=%h exp=%h", dif.dm_wdata, exp); end
  endtask

  task automatic test_random();
    logic exp_we;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(59) == 0);
      dif.halt = ($urandom_range(7) == 0);
      dif.alu_result = 16'($urandom);
      dif.im_rdata = 16'($urandom);
      dif.dm_rdata = 16'($urandom);
      drive(4'($urandom), 16'($urandom & $urandom & $urandom),
            16'($urandom & $urandom & $urandom), 16'($urandom & $urandom & $urandom & $urandom));
      #1;
      exp_we = dif.write_en[11] & ~dif.halt & ~rst;
      n_checks++; if (dif.dm_we !== exp_we) begin n_errors++; $display("FAIL rnd_dm_we cyc=%0d got=%b exp=%b", n, dif.dm_we, exp_we); end
      tick();
      n_checks++; if (dif.ac_out !== m_ac)    begin n_errors++; $display("FAIL rnd_ac cyc=%0d got=%h exp=%h", n, dif.ac_out, m_ac); end
      n_checks++; if (dif.r_out !== m_r)      begin n_errors++; $display("FAIL rnd_r cyc=%0d got=%h exp=%h", n, dif.r_out, m_r); end
      n_checks++; if (dif.im_addr !== m_pc)   begin n_errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", n, dif.im_addr, m_pc); end
      n_checks++; if (dif.dm_addr !== m_ar)   begin n_errors++; $display("FAIL rnd_ar cyc=%0d got=%h exp=%h", n, dif.dm_addr, m_ar); end
      n_checks++; if (dif.dm_wdata !== m_bus) begin n_errors++; $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", n, dif.dm_wdata, m_bus); end
      n_checks++; if (dif.instruction !== m_ir[5:0]) begin n_errors++; $display("FAIL rnd_ir cyc=%0d got=%h exp=%h", n, dif.instruction, m_ir[5:0]); end
      n_checks++; if (dif.z !== (m_ac == 16'h0)) begin n_errors++; $display("FAIL rnd_z cyc=%0d got=%b exp=%b", n, dif.z, (m_ac == 16'h0)); end
    end
    rst = 1'b0;
    dif.halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_alu_wrap();
    test_halt();
    test_r5();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
